// File: rtl/rtc_pkg.sv
// Shared types, limits and BCD helpers for the real-time clock with alarms.
// Time values are kept as packed BCD nibbles throughout.
package rtc_pkg;

  localparam logic [7:0] MAX_HOUR = 8'h23;
  localparam logic [7:0] MAX_MS   = 8'h59;

  typedef struct packed {
    logic [3:0] hT;
    logic [3:0] hO;
    logic [3:0] mT;
    logic [3:0] mO;
    logic [3:0] sT;
    logic [3:0] sO;
  } bcd_time_t;

  typedef struct packed {
    logic [3:0] hT;
    logic [3:0] hO;
    logic [3:0] mT;
    logic [3:0] mO;
  } bcd_hm_t;

  typedef enum logic {
    SNZ_IDLE,
    SNZ_ARMED
  } snz_state_e;

  function automatic logic [7:0] bcdInc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcdToBin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic logic [7:0] binToBcd(input logic [6:0] b);
    logic [6:0] tens;
    tens = b / 7'd10;
    return {tens[3:0], 4'(b - tens * 7'd10)};
  endfunction

  // Snooze never adds more than 59 minutes, so at most one hour carry occurs.
  function automatic bcd_hm_t bcdAddMinutes(input bcd_hm_t t, input logic [5:0] addMin);
    logic [6:0] h;
    logic [6:0] m;
    h = bcdToBin({t.hT, t.hO});
    m = bcdToBin({t.mT, t.mO}) + 7'(addMin);
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = h + 7'd1;
    end
    if (h >= 7'd24) h = h - 7'd24;
    return {binToBcd(h), binToBcd(m)};
  endfunction

  function automatic logic [7:0] hourTo12(input logic [7:0] h);
    logic [6:0] b;
    b = bcdToBin(h);
    if (b == 7'd0) return 8'h12;
    if (b > 7'd12) return binToBcd(b - 7'd12);
    return h;
  endfunction

  function automatic logic isLegalHm(input bcd_hm_t t);
    return (t.mO <= 4'd9) && (t.mT <= 4'd5) && (t.hO <= 4'd9) &&
           ({t.hT, t.hO} <= MAX_HOUR);
  endfunction

  function automatic logic isLegalTime(input bcd_time_t t);
    return (t.sO <= 4'd9) && (t.sT <= 4'd5) && isLegalHm({t.hT, t.hO, t.mT, t.mO});
  endfunction

endpackage

// File: rtl/rtc_alarm_if.sv
// Host-side bus of the RTC: time/alarm writes, ack/snooze strobes and status.
interface rtc_alarm_if #(parameter int NUM_ALARMS = 2);
  import rtc_pkg::*;

  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  set_valid;
  bcd_time_t             set_time;
  logic                  alarm_wr;
  logic [SEL_W-1:0]      alarm_sel;
  bcd_hm_t               alarm_time;
  logic                  alarm_en;
  logic                  ack;
  logic                  snooze;
  logic                  mode_12h;
  bcd_time_t             time_bcd;
  bcd_time_t             disp_bcd;
  logic                  pm;
  logic                  sec_tick;
  logic [NUM_ALARMS-1:0] alarm_ring;
  logic                  set_err;

  modport master (
    output set_valid, set_time, alarm_wr, alarm_sel, alarm_time, alarm_en,
    output ack, snooze, mode_12h,
    input  time_bcd, disp_bcd, pm, sec_tick, alarm_ring, set_err
  );

  modport slave (
    input  set_valid, set_time, alarm_wr, alarm_sel, alarm_time, alarm_en,
    input  ack, snooze, mode_12h,
    output time_bcd, disp_bcd, pm, sec_tick, alarm_ring, set_err
  );

endinterface

// File: rtl/rtc_alarm_bcd_cnt.sv
// Two-digit BCD counter wrapping MAX->00; next_o exposes the post-edge value
// so the parent can detect alarm matches in the same cycle the time changes.
module bcd_cnt #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] loadVal_i,
  output logic [7:0] value_o,
  output logic [7:0] next_o,
  output logic       carry_o
);
  import rtc_pkg::*;

  logic [7:0] value_q;

  assign carry_o = inc_i && (value_q == MAX);
  assign value_o = value_q;

  always_comb begin
    next_o = value_q;
    if (inc_i) next_o = carry_o ? 8'h00 : bcdInc(value_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      value_q <= 8'h00;
    else if (load_i) value_q <= loadVal_i;
    else             value_q <= next_o;
  end

endmodule

// File: rtl/rtc_alarm.sv
// Real-time clock with a 1 Hz prescaler, per-slot alarms, ack/snooze and a
// 12/24 h display view.
module rtc_alarm
  import rtc_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int NUM_ALARMS = 2,
  parameter int SNOOZE_MIN = 5
) (
  input logic        clock,
  input logic        reset,
  rtc_alarm_if.slave bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic tick, loadOk, advance, setBad, wrBad;
  logic secTick_q, setErr_q;

  logic [7:0] secVal, minVal, hourVal, secNext, minNext, hourNext;
  logic secCarry, minCarry, unusedDayWrap;
  bcd_time_t nowTime, nextTime;
  logic [23:0] dispTime;

  bcd_hm_t               almTime_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] almEn_q;
  logic [NUM_ALARMS-1:0] match;

  snz_state_e            snzState_q, snzState_d;
  logic [NUM_ALARMS-1:0] snzMask_q, snzMask_d;
  bcd_hm_t               snzTarget_q, snzTarget_d;
  logic [NUM_ALARMS-1:0] ring_q, ring_d;
  logic                  snzHit;

  // A legal load wins over a coincident tick, so time only advances otherwise.
  assign tick    = (presc_q == PRESC_LAST);
  assign loadOk  = bus.set_valid && isLegalTime(bus.set_time);
  assign setBad  = bus.set_valid && !isLegalTime(bus.set_time);
  assign advance = tick && !loadOk;
  assign wrBad   = bus.alarm_wr &&
                   (!isLegalHm(bus.alarm_time) || (int'(bus.alarm_sel) >= NUM_ALARMS));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (tick || loadOk) presc_d = '0;
  end

  bcd_cnt #(.MAX(MAX_MS)) uSec (
    .clock     (clock),
    .reset     (reset),
    .inc_i     (advance),
    .load_i    (loadOk),
    .loadVal_i ({bus.set_time.sT, bus.set_time.sO}),
    .value_o   (secVal),
    .next_o    (secNext),
    .carry_o   (secCarry)
  );

  bcd_cnt #(.MAX(MAX_MS)) uMin (
    .clock     (clock),
    .reset     (reset),
    .inc_i     (secCarry),
    .load_i    (loadOk),
    .loadVal_i ({bus.set_time.mT, bus.set_time.mO}),
    .value_o   (minVal),
    .next_o    (minNext),
    .carry_o   (minCarry)
  );

  bcd_cnt #(.MAX(MAX_HOUR)) uHour (
    .clock     (clock),
    .reset     (reset),
    .inc_i     (minCarry),
    .load_i    (loadOk),
    .loadVal_i ({bus.set_time.hT, bus.set_time.hO}),
    .value_o   (hourVal),
    .next_o    (hourNext),
    .carry_o   (unusedDayWrap)
  );

  assign nowTime  = {hourVal, minVal, secVal};
  assign nextTime = {hourNext, minNext, secNext};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) almTime_q[i] <= '0;
      almEn_q <= '0;
    end else if (bus.alarm_wr && !wrBad) begin
      almTime_q[bus.alarm_sel] <= bus.alarm_time;
      almEn_q[bus.alarm_sel]   <= bus.alarm_en;
    end
  end

  // Matches are taken against the post-tick time so loads never trigger a ring.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (advance && almEn_q[k] && (nextTime == {almTime_q[k], 8'h00})) match[k] = 1'b1;
    end
  end

  assign snzHit = (snzState_q == SNZ_ARMED) && advance &&
                  (nextTime == {snzTarget_q, 8'h00});

  always_comb begin
    snzState_d  = snzState_q;
    snzMask_d   = snzMask_q;
    snzTarget_d = snzTarget_q;
    ring_d      = ring_q;
    if (bus.ack) begin
      ring_d     = '0;
      snzState_d = SNZ_IDLE;
    end else if (bus.snooze && (|ring_q)) begin
      ring_d      = '0;
      snzState_d  = SNZ_ARMED;
      snzMask_d   = ring_q;
      snzTarget_d = bcdAddMinutes({hourVal, minVal}, 6'(SNOOZE_MIN));
    end else if (snzHit) begin
      snzState_d = SNZ_IDLE;
    end
    ring_d = ring_d | match | (snzHit ? snzMask_q : '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      secTick_q   <= 1'b0;
      setErr_q    <= 1'b0;
      snzState_q  <= SNZ_IDLE;
      snzMask_q   <= '0;
      snzTarget_q <= '0;
      ring_q      <= '0;
    end else begin
      presc_q     <= presc_d;
      secTick_q   <= advance;
      setErr_q    <= setBad || wrBad;
      snzState_q  <= snzState_d;
      snzMask_q   <= snzMask_d;
      snzTarget_q <= snzTarget_d;
      ring_q      <= ring_d;
    end
  end

  always_comb begin
    dispTime = nowTime;
    if (bus.mode_12h) dispTime = {hourTo12(hourVal), minVal, secVal};
  end

  assign bus.time_bcd   = nowTime;
  assign bus.disp_bcd   = dispTime;
  assign bus.pm         = (hourVal >= 8'h12);
  assign bus.sec_tick   = secTick_q;
  assign bus.alarm_ring = ring_q;
  assign bus.set_err    = setErr_q;

endmodule

// File: tb/tb_rtc_alarm.sv
// Directed bench for rtc_alarm with a 4-cycle second (CLK_HZ=4), two slots
// and a 5-minute snooze; expected values are hand-computed.
module tb_rtc_alarm;
  import rtc_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   ticks;

  rtc_alarm_if #(.NUM_ALARMS(2)) bus ();

  rtc_alarm #(.CLK_HZ(4), .NUM_ALARMS(2), .SNOOZE_MIN(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic loadTime(input logic [23:0] t);
    bus.set_valid = 1'b1;
    bus.set_time  = t;
    applyStimulus(1);
    bus.set_valid = 1'b0;
  endtask

  task automatic writeAlarm(input logic sel, input logic [15:0] hm, input logic en);
    bus.alarm_wr   = 1'b1;
    bus.alarm_sel  = sel;
    bus.alarm_time = hm;
    bus.alarm_en   = en;
    applyStimulus(1);
    bus.alarm_wr   = 1'b0;
  endtask

  task automatic pulseAck();
    bus.ack = 1'b1;
    applyStimulus(1);
    bus.ack = 1'b0;
  endtask

  task automatic pulseSnooze();
    bus.snooze = 1'b1;
    applyStimulus(1);
    bus.snooze = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    bus.set_valid  = 1'b0;
    bus.set_time   = '0;
    bus.alarm_wr   = 1'b0;
    bus.alarm_sel  = '0;
    bus.alarm_time = '0;
    bus.alarm_en   = 1'b0;
    bus.ack        = 1'b0;
    bus.snooze     = 1'b0;
    bus.mode_12h   = 1'b0;
    $display("[TB] start");

    applyStimulus(2);
    checkOutput("rst_time", 32'(bus.time_bcd), 32'h000000);
    checkOutput("rst_ring", 32'(bus.alarm_ring), 32'h0);
    checkOutput("rst_err", 32'(bus.set_err), 32'h0);
    checkOutput("rst_tick", 32'(bus.sec_tick), 32'h0);
    reset = 1'b1;
    applyStimulus(1);

    // Midnight wrap with two second ticks
    loadTime(24'h235958);
    checkOutput("load_time", 32'(bus.time_bcd), 32'h235958);
    ticks = 0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1);
      if (bus.sec_tick) ticks++;
      if (i == 3) checkOutput("pre_tick", 32'(bus.time_bcd), 32'h235958);
      if (i == 4) checkOutput("tick_59", 32'(bus.time_bcd), 32'h235959);
    end
    checkOutput("midnight", 32'(bus.time_bcd), 32'h000000);
    checkOutput("tick_count", 32'(ticks), 32'd2);

    loadTime(24'h095959);
    applyStimulus(4);
    checkOutput("hour_carry", 32'(bus.time_bcd), 32'h100000);

    // Illegal writes
    bus.set_valid = 1'b1;
    bus.set_time  = 24'h240000;
    applyStimulus(1);
    bus.set_valid = 1'b0;
    checkOutput("err_hour24", 32'(bus.set_err), 32'h1);
    checkOutput("err_time_kept", 32'(bus.time_bcd), 32'h100000);
    applyStimulus(1);
    checkOutput("err_pulse_end", 32'(bus.set_err), 32'h0);
    bus.set_valid = 1'b1;
    bus.set_time  = 24'h125A00;
    applyStimulus(1);
    bus.set_valid = 1'b0;
    checkOutput("err_digit", 32'(bus.set_err), 32'h1);
    checkOutput("err_digit_kept", 32'(bus.time_bcd), 32'h100000);
    writeAlarm(1'b1, 16'h2400, 1'b1);
    checkOutput("err_alarm", 32'(bus.set_err), 32'h1);
    writeAlarm(1'b1, 16'h0730, 1'b1);
    checkOutput("alarm_ok", 32'(bus.set_err), 32'h0);

    // Slot 1 rings on tick arrival and holds until ack
    loadTime(24'h072959);
    applyStimulus(3);
    checkOutput("ring_before", 32'(bus.alarm_ring), 32'h0);
    applyStimulus(1);
    checkOutput("ring_time", 32'(bus.time_bcd), 32'h073000);
    checkOutput("ring_slot1", 32'(bus.alarm_ring), 32'h2);
    applyStimulus(2);
    checkOutput("ring_held", 32'(bus.alarm_ring), 32'h2);
    pulseAck();
    checkOutput("ring_ack", 32'(bus.alarm_ring), 32'h0);

    loadTime(24'h073000);
    checkOutput("load_on_alarm", 32'(bus.alarm_ring), 32'h0);
    applyStimulus(4);
    checkOutput("load_on_alarm_next", 32'(bus.alarm_ring), 32'h0);

    // Snooze across midnight: 23:58 + 5 min -> 00:03
    writeAlarm(1'b0, 16'h2358, 1'b1);
    loadTime(24'h235759);
    applyStimulus(4);
    checkOutput("ring_slot0", 32'(bus.alarm_ring), 32'h1);
    pulseSnooze();
    checkOutput("snooze_clear", 32'(bus.alarm_ring), 32'h0);
    loadTime(24'h000258);
    applyStimulus(4);
    checkOutput("snooze_wait_time", 32'(bus.time_bcd), 32'h000259);
    checkOutput("snooze_wait_ring", 32'(bus.alarm_ring), 32'h0);
    applyStimulus(4);
    checkOutput("snooze_time", 32'(bus.time_bcd), 32'h000300);
    checkOutput("snooze_rering", 32'(bus.alarm_ring), 32'h1);
    pulseAck();
    checkOutput("snooze_ack", 32'(bus.alarm_ring), 32'h0);

    loadTime(24'h235759);
    applyStimulus(4);
    pulseSnooze();
    pulseAck();
    loadTime(24'h000259);
    applyStimulus(4);
    checkOutput("ack_cancel_time", 32'(bus.time_bcd), 32'h000300);
    checkOutput("ack_cancels_snooze", 32'(bus.alarm_ring), 32'h0);

    // 12 h display view
    bus.mode_12h = 1'b1;
    loadTime(24'h001500);
    checkOutput("disp_midnight", 32'(bus.disp_bcd), 32'h121500);
    checkOutput("pm_midnight", 32'(bus.pm), 32'h0);
    checkOutput("time_24h_kept", 32'(bus.time_bcd), 32'h001500);
    loadTime(24'h130509);
    checkOutput("disp_13", 32'(bus.disp_bcd), 32'h010509);
    checkOutput("pm_13", 32'(bus.pm), 32'h1);
    loadTime(24'h120000);
    checkOutput("disp_noon", 32'(bus.disp_bcd), 32'h120000);
    checkOutput("pm_noon", 32'(bus.pm), 32'h1);
    loadTime(24'h235000);
    checkOutput("disp_23", 32'(bus.disp_bcd), 32'h115000);
    bus.mode_12h = 1'b0;
    #1;
    checkOutput("disp_24h", 32'(bus.disp_bcd), 32'h235000);

    // Load beats a coincident tick and restarts the prescaler
    loadTime(24'h100000);
    applyStimulus(3);
    loadTime(24'h111111);
    checkOutput("set_beats_tick", 32'(bus.time_bcd), 32'h111111);
    checkOutput("set_no_tick", 32'(bus.sec_tick), 32'h0);
    applyStimulus(4);
    checkOutput("after_coincident", 32'(bus.time_bcd), 32'h111112);
    loadTime(24'h100000);
    applyStimulus(1);
    loadTime(24'h111111);
    applyStimulus(3);
    checkOutput("presc_restart", 32'(bus.time_bcd), 32'h111111);
    applyStimulus(1);
    checkOutput("presc_first_tick", 32'(bus.time_bcd), 32'h111112);

    // Reset while ringing clears everything, including alarm slots
    loadTime(24'h072959);
    applyStimulus(4);
    checkOutput("ring_pre_reset", 32'(bus.alarm_ring), 32'h2);
    reset = 1'b0;
    #1;
    checkOutput("reset_ring", 32'(bus.alarm_ring), 32'h0);
    checkOutput("reset_time", 32'(bus.time_bcd), 32'h000000);
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(1);
    loadTime(24'h072959);
    applyStimulus(4);
    checkOutput("slots_cleared_time", 32'(bus.time_bcd), 32'h073000);
    checkOutput("slots_cleared", 32'(bus.alarm_ring), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/rtc_alarm.md
RTC_ALARM -- requirements
Module: rtc_alarm

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock cycles per second.
REQ-002 Parameter NUM_ALARMS, default 2, number of independent alarm slots (1..8).
REQ-003 Parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
REQ-004 clock  in  1  single system clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 set_valid  in  1  one-cycle strobe; load set_time.
REQ-007 set_time  in  24  BCD HH:MM:SS as {Ht,Ho,Mt,Mo,St,So}, 4 bits per digit.
REQ-008 alarm_wr  in  1  one-cycle strobe; write alarm slot alarm_sel.
REQ-009 alarm_sel  in  $clog2(NUM_ALARMS) (minimum 1)  slot index.
REQ-010 alarm_time  in  16  BCD HH:MM.
REQ-011 alarm_en  in  1  enable bit written with the slot.
REQ-012 ack  in  1  one-cycle strobe; silence all ringing alarms.
REQ-013 snooze  in  1  one-cycle strobe; silence and re-arm after SNOOZE_MIN.
REQ-014 mode_12h  in  1  display format select.
REQ-015 time_bcd  out  24  current time, 24 h BCD.
REQ-016 disp_bcd  out  24  current time in the format selected by mode_12h.
REQ-017 pm  out  1  high when hour is 12..23.
REQ-018 sec_tick  out  1  one-cycle pulse on each seconds increment.
REQ-019 alarm_ring  out  NUM_ALARMS  latched per-slot ringing flags.
REQ-020 set_err  out  1  one-cycle pulse on a rejected write.

Function
REQ-021 Prescaler counts 0..CLK_HZ-1; at CLK_HZ-1 it wraps to 0 and increments time in the same edge.
REQ-022 sec_tick asserts in the cycle time_bcd shows the incremented value.
REQ-023 Time carries So->St->Mo->Mt->Ho/Ht; seconds and minutes wrap 59->00; 23:59:59 wraps to 00:00:00.
REQ-024 set_valid with a legal time loads it and clears the prescaler; it takes priority over a coincident tick (no increment that cycle).
REQ-025 Illegal set_time or alarm_time (any digit >9, tens of min/sec >5, hour >23) is ignored; set_err pulses the next cycle.
REQ-026 alarm_wr with a legal value stores {alarm_time, alarm_en} into slot alarm_sel; alarm_sel >= NUM_ALARMS is ignored and pulses set_err.
REQ-027 Slot k rings when enabled and the time reaches alarm HH:MM:00; the alarm_ring[k] bit sets in the same cycle as the matching time_bcd.
REQ-028 A set_valid load that lands exactly on HH:MM:00 triggers no alarm; only tick-driven arrival matches.
REQ-029 alarm_ring bits stay set until ack, snooze, or reset.
REQ-030 ack clears all alarm_ring bits and cancels any pending snooze.
REQ-031 snooze while any bit rings clears the bits, records the mask, and sets snooze target = current HH:MM + SNOOZE_MIN, wrapping past 23:59.
REQ-032 At target HH:MM:00 the recorded mask re-rings; a second snooze replaces the target.
REQ-033 snooze with no alarm ringing is ignored.
REQ-034 Ack or snooze in the same cycle as a new match: the new match wins and its bit stays set.
REQ-035 disp_bcd in 12 h mode: hour 00->12, 13..23->01..11, 01..12 unchanged; minutes and seconds pass through.
REQ-036 mode_12h is combinational on disp_bcd only; it affects no stored state.

Reset
REQ-037 Reset drives time 00:00:00 and clears the prescaler, all alarm slots (time 00:00, disabled), snooze state, alarm_ring, set_err and sec_tick.
REQ-038 Reset mid-ring or mid-snooze clears all pending state immediately; there is no ringing after release.

Structure
REQ-039 Package rtc_pkg holds typedef bcd_time_t (packed struct of six nibbles), bcd_hm_t (four nibbles), and constants MAX_HOUR=8'h23 and MAX_MS=8'h59.
REQ-040 Sub-module bcd_cnt (two-digit BCD counter: parametrised max, inc and load inputs, carry output) is instantiated for seconds, minutes and hours.
REQ-041 The BCD add-with-wrap for the snooze target is a function in rtc_pkg.

Verification (CLK_HZ=4, NUM_ALARMS=2, SNOOZE_MIN=5)
REQ-042 Load 23:59:58, wait 8 cycles -> 23:59:59, then 00:00:00, with 2 sec_tick pulses.
REQ-043 Load 24:00:00 -> set_err pulses; time is unchanged. Load 12:5A:00 -> set_err pulses.
REQ-044 Alarm slot1=07:30 enabled, load 07:29:59 -> alarm_ring=2'b10 at 07:30:00; ack -> 2'b00.
REQ-045 Alarm 23:58 rings, snooze -> cleared; re-rings at 00:03:00 (midnight wrap).
REQ-046 time 00:15:00 with mode_12h=1 -> disp 12:15:00, pm=0; time 13:05:09 -> disp 01:05:09, pm=1.
REQ-047 set_valid coincident with the tick cycle -> loaded value shown and prescaler restarts; reset asserted while ringing -> ring cleared and time 00:00:00.
